// File: rtl/adder_result_checker_if.sv
// Operand/result bus between the adder stimulus side and the result checker.
// Handshake: no ready. in_valid marks operands presented this cycle and guard marks a
// valid res this cycle; both are single-cycle qualifiers sampled on the rising edge.
interface adder_result_checker_if #(
    parameter int W = 4
);
    logic             in_valid;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             guard;
    logic [2*W+1:0]   res;

    modport master (output in_valid, a, b, guard, res);
    modport slave  (input  in_valid, a, b, guard, res);
endinterface

// File: rtl/adder_result_checker.sv
// Scoreboard for the generated Adder: queues operand pairs and checks each guarded
// result {p,g,s,t} against a+b / a+b+1, keeping pass/error statistics.
module adder_result_checker #(
    parameter int W           = 4,
    parameter int DEPTH       = 4,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    adder_result_checker_if.slave      bus,
    output logic                       mismatch,
    output logic [15:0]                pass_count,
    output logic [15:0]                err_count,
    output logic [W-1:0]               err_a,
    output logic [W-1:0]               err_b,
    output logic [2*W+1:0]             err_res,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       halted,
    output logic [$clog2(DEPTH):0]     pending,
    output logic [1:0]                 dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [2*W-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count, count_nx;

    logic           active, push_req, pop_req, empty, full;
    logic           do_write, do_cmp, do_under, cmp_fail;
    logic [W-1:0]   head_a, head_b;
    logic [W:0]     sum0, sum1;
    logic [2*W+1:0] exp_res;

    assign active   = (state != HALT);
    assign push_req = active & bus.in_valid;
    assign pop_req  = active & bus.guard;
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));

    assign {head_a, head_b} = mem[rd_ptr];
    assign sum0    = {1'b0, head_a} + {1'b0, head_b};
    assign sum1    = sum0 + (W+1)'(1);
    assign exp_res = {sum1[W], sum0[W], sum0[W-1:0], sum1[W-1:0]};

    // A push that coincides with a pop on an empty queue is discarded: that pop is an
    // underflow, and keeping the entry would mis-pair every later result.
    assign do_cmp   = pop_req & ~empty;
    assign do_under = pop_req & empty;
    assign cmp_fail = do_cmp & (bus.res != exp_res);
    assign do_write = push_req & (pop_req ? ~empty : ~full);
    assign count_nx = count + CW'(do_write) - CW'(do_cmp);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (do_write) state_nx = BUSY;
            BUSY:    if (count_nx == '0) state_nx = IDLE;
            HALT:    state_nx = HALT;
            default: state_nx = IDLE;
        endcase
        if (cmp_fail && STOP_ON_ERR) state_nx = HALT;
    end

    assign halted    = (state == HALT);
    assign dbg_state = state;
    assign pending   = count;

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= {bus.a, bus.b};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            mismatch   <= 1'b0;
            pass_count <= '0;
            err_count  <= '0;
            err_a      <= '0;
            err_b      <= '0;
            err_res    <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            mismatch <= cmp_fail;
            count    <= count_nx;
            if (do_write) wr_ptr <= wr_ptr + AW'(1);
            if (do_cmp)   rd_ptr <= rd_ptr + AW'(1);
            if (do_cmp && !cmp_fail && pass_count != 16'hFFFF)
                pass_count <= pass_count + 16'd1;
            if ((cmp_fail || do_under) && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
            if (cmp_fail) begin
                err_a   <= head_a;
                err_b   <= head_b;
                err_res <= bus.res;
            end
            if (push_req && !pop_req && full) overflow  <= 1'b1;
            if (do_under)                     underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_adder_result_checker.sv
// Randomized and directed bench for adder_result_checker against a queue-based model.
module tb_adder_result_checker;
    localparam int W     = 4;
    localparam int DEPTH = 4;
    localparam int RW    = 2*W+2;
    localparam int PW    = $clog2(DEPTH)+1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_result_checker_if #(.W(W)) bus0 ();
    adder_result_checker_if #(.W(W)) bus1 ();

    logic          mm0, mm1, ovf0, ovf1, unf0, unf1, hlt0, hlt1;
    logic [15:0]   pc0, pc1, ec0, ec1;
    logic [W-1:0]  ea0, ea1, eb0, eb1;
    logic [RW-1:0] er0, er1;
    logic [PW-1:0] pd0, pd1;
    logic [1:0]    st0, st1;

    adder_result_checker #(.W(W), .DEPTH(DEPTH), .STOP_ON_ERR(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .mismatch(mm0), .pass_count(pc0),
        .err_count(ec0), .err_a(ea0), .err_b(eb0), .err_res(er0), .overflow(ovf0),
        .underflow(unf0), .halted(hlt0), .pending(pd0), .dbg_state(st0));

    adder_result_checker #(.W(W), .DEPTH(DEPTH), .STOP_ON_ERR(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .mismatch(mm1), .pass_count(pc1),
        .err_count(ec1), .err_a(ea1), .err_b(eb1), .err_res(er1), .overflow(ovf1),
        .underflow(unf1), .halted(hlt1), .pending(pd1), .dbg_state(st1));

    // sel picks which DUT is driven and observed
    bit            sel = 1'b0;
    logic          o_mm, o_ovf, o_unf, o_hlt;
    logic [15:0]   o_pc, o_ec;
    logic [W-1:0]  o_ea, o_eb;
    logic [RW-1:0] o_er;
    logic [PW-1:0] o_pd;

    always_comb begin
        o_mm  = sel ? mm1  : mm0;
        o_ovf = sel ? ovf1 : ovf0;
        o_unf = sel ? unf1 : unf0;
        o_hlt = sel ? hlt1 : hlt0;
        o_pc  = sel ? pc1  : pc0;
        o_ec  = sel ? ec1  : ec0;
        o_ea  = sel ? ea1  : ea0;
        o_eb  = sel ? eb1  : eb0;
        o_er  = sel ? er1  : er0;
        o_pd  = sel ? pd1  : pd0;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*W-1:0] exp_q[$];
    int             m_pass, m_err;
    logic [W-1:0]   m_ea, m_eb;
    logic [RW-1:0]  m_eres;
    bit             m_ovf, m_unf, m_halt, m_mm, m_stop;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] ref_res(input int a, input int b);
        int m, s0, s1;
        logic [W-1:0] s, t;
        logic g, p;
        m  = 1 << W;
        s0 = a + b;
        s1 = a + b + 1;
        s  = W'(s0 % m);
        t  = W'(s1 % m);
        g  = (s0 >= m);
        p  = (s1 >= m);
        return {p, g, s, t};
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic model_update(input bit iv, input logic [W-1:0] a, input logic [W-1:0] b,
                                input bit g, input logic [RW-1:0] r);
        bit was_empty;
        logic [2*W-1:0] head;
        m_mm = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            m_pass = 0; m_err = 0; m_ea = '0; m_eb = '0; m_eres = '0;
            m_ovf = 0; m_unf = 0; m_halt = 0;
        end else if (!m_halt) begin
            was_empty = (exp_q.size() == 0);
            if (g) begin
                if (was_empty) begin
                    m_unf = 1'b1;
                    m_err = sat_inc(m_err);
                end else begin
                    head = exp_q.pop_front();
                    if (ref_res(int'(head[2*W-1:W]), int'(head[W-1:0])) == r) begin
                        m_pass = sat_inc(m_pass);
                    end else begin
                        m_err  = sat_inc(m_err);
                        m_mm   = 1'b1;
                        m_ea   = head[2*W-1:W];
                        m_eb   = head[W-1:0];
                        m_eres = r;
                        if (m_stop) m_halt = 1'b1;
                    end
                end
            end
            if (iv && !(g && was_empty)) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({a, b});
                else                      m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        check_eq("mismatch",   32'(o_mm),  32'(m_mm));
        check_eq("pass_count", 32'(o_pc),  32'(m_pass));
        check_eq("err_count",  32'(o_ec),  32'(m_err));
        check_eq("err_a",      32'(o_ea),  32'(m_ea));
        check_eq("err_b",      32'(o_eb),  32'(m_eb));
        check_eq("err_res",    32'(o_er),  32'(m_eres));
        check_eq("overflow",   32'(o_ovf), 32'(m_ovf));
        check_eq("underflow",  32'(o_unf), 32'(m_unf));
        check_eq("halted",     32'(o_hlt), 32'(m_halt));
        check_eq("pending",    32'(o_pd),  32'(exp_q.size()));
    endtask

    task automatic step(input bit iv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit g, input logic [RW-1:0] r);
        bus0.in_valid = sel ? 1'b0 : iv;  bus1.in_valid = sel ? iv : 1'b0;
        bus0.guard    = sel ? 1'b0 : g;   bus1.guard    = sel ? g  : 1'b0;
        bus0.a = a; bus0.b = b; bus0.res = r;
        bus1.a = a; bus1.b = b; bus1.res = r;
        @(posedge clk);
        #1;
        model_update(iv, a, b, g, r);
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(0, '0, '0, 0, '0);
        rst_n = 1'b1;
    endtask

    function automatic logic [RW-1:0] head_res();
        if (exp_q.size() == 0) return RW'($urandom);
        return ref_res(int'(exp_q[0][2*W-1:W]), int'(exp_q[0][W-1:0]));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] r;
        logic [7:0]    k, prev;
        m_stop = 1'b0;
        do_reset();

        // 3+5 with two cycles of latency
        step(1, 4'd3, 4'd5, 0, '0);
        step(0, '0, '0, 0, '0);
        step(0, '0, '0, 1, 10'b00_1000_1001);
        check_eq("tp1_pass", 32'(o_pc), 32'd1);
        check_eq("tp1_pend", 32'(o_pd), 32'd0);

        // carry-out cases: g and p set, then p only
        step(1, 4'hF, 4'h1, 0, '0);
        step(0, '0, '0, 1, 10'b11_0000_0001);
        step(1, 4'hF, 4'h0, 0, '0);
        step(0, '0, '0, 1, 10'b10_1111_0000);
        check_eq("tp2_pass", 32'(o_pc), 32'd3);

        // wrong result for 2+2 must pulse mismatch for one cycle
        step(1, 4'd2, 4'd2, 0, '0);
        step(0, '0, '0, 1, 10'b00_0101_0101);
        check_eq("tp3_mm", 32'(o_mm), 32'd1);
        check_eq("tp3_err_res", 32'(o_er), 32'(10'b00_0101_0101));
        step(0, '0, '0, 0, '0);

        // overflow then drain past empty
        do_reset();
        for (int i = 0; i < 5; i++) step(1, W'($urandom), W'($urandom), 0, '0);
        check_eq("tp4_ovf", 32'(o_ovf), 32'd1);
        check_eq("tp4_pend", 32'(o_pd), 32'd4);
        for (int i = 0; i < 4; i++) begin
            r = head_res();
            step(0, '0, '0, 1, r);
        end
        step(0, '0, '0, 1, '0);
        check_eq("tp4_pass", 32'(o_pc), 32'd4);
        check_eq("tp4_unf", 32'(o_unf), 32'd1);
        check_eq("tp4_err", 32'(o_ec), 32'd1);

        // full sweep with a 1-cycle-latency adder
        do_reset();
        prev = '0;
        for (int i = 0; i <= 256; i++) begin
            k = 8'(i);
            step(i < 256, k[7:4], k[3:0], i > 0, ref_res(int'(prev[7:4]), int'(prev[3:0])));
            prev = k;
        end
        check_eq("sweep_pass", 32'(o_pc), 32'd256);
        check_eq("sweep_err", 32'(o_ec), 32'd0);

        // random traffic with occasional corrupted results
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = head_res();
            if ($urandom_range(0, 7) == 0) r = r ^ (RW'(1) << $urandom_range(0, RW-1));
            step(bit'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                 $urandom_range(0, 2) != 0, r);
        end

        // stop-on-error instance
        sel = 1'b1;
        m_stop = 1'b1;
        do_reset();
        step(1, 4'd2, 4'd2, 0, '0);
        step(1, 4'd1, 4'd6, 0, '0);
        step(1, 4'd7, 4'd7, 1, 10'b00_0101_0101);
        check_eq("halt_set", 32'(o_hlt), 32'd1);
        for (int i = 0; i < 6; i++) begin
            r = head_res();
            step(1, W'($urandom), W'($urandom), 1, r);
        end
        check_eq("halt_pend", 32'(o_pd), 32'd2);
        check_eq("halt_pass", 32'(o_pc), 32'd0);
        do_reset();
        check_eq("rst_halted", 32'(o_hlt), 32'd0);
        check_eq("rst_pend", 32'(o_pd), 32'd0);
        step(1, 4'd1, 4'd1, 0, '0);
        step(0, '0, '0, 1, ref_res(1, 1));
        check_eq("post_rst_pass", 32'(o_pc), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
